uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter: accepts parallel words into a FIFO and serialises them on `tx` as 8N1-style frames at a baud rate set by a clock divider. It is the transmit end of the system's UART link and pairs with the receive path that supplies `r_data`/`rx_empty`. Its write side uses the same `wr_uart`/`w_data`/`tx_full` handshake as the existing UART wrapper, so an echo or command controller drives it directly.

## Interface
- `DVSR`, 79: baud divider; one oversample tick every `DVSR+1` clocks (16 ticks per bit).
- `DVSR_BIT`, 7: width of the divider counter; must satisfy `DVSR < 2^DVSR_BIT`.
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: stop-bit length in oversample ticks (16 = 1 stop bit).
- `FIFO_W`, 4: FIFO address width; depth is `2^FIFO_W`.

- `clk` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_uart` in 1: write strobe; pushes `w_data` when `tx_full`=0.
- `w_data` in DBIT: word to transmit.
- `tx_full` out 1: FIFO full.
- `tx_empty` out 1: FIFO empty.
- `tx_busy` out 1: serialiser not in IDLE.
- `tx_done_tick` out 1: one-clock pulse at the end of each stop bit.
- `tx` out 1: serial line; idle high; registered output.

## Operation
- Reset (`reset`=0, asynchronous): FIFO pointers cleared, FSM in IDLE, divider and counters 0. Outputs: `tx`=1, `tx_full`=0, `tx_empty`=1, `tx_busy`=0, `tx_done_tick`=0. A frame in progress is aborted and `tx` returns high immediately.
- FIFO: circular buffer with read/write pointers and full/empty flags.
  - A write occurs on `wr_uart`=1 and `tx_full`=0.
  - A write while full is dropped, even if a pop happens in the same cycle.
  - A simultaneous write and pop on a non-empty, non-full FIFO keeps the occupancy constant.
  - Pointers wrap modulo `2^FIFO_W`.
- Divider: held at 0 in IDLE; otherwise counts `0..DVSR` and wraps. `s_tick` is asserted in the cycle the count equals `DVSR`.
- FSM states: IDLE, START, DATA, STOP. Counters: `s_cnt` (0-15), `n_cnt` (0 to `DBIT-1`), shift register `b_reg`.
  - IDLE: if `tx_empty`=0, pop the head into `b_reg`, clear `s_cnt`, and go to START. `tx`=1.
  - START: `tx`=0. On `s_tick`, if `s_cnt`=15, clear `s_cnt` and `n_cnt` and go to DATA; otherwise increment `s_cnt`.
  - DATA: `tx`=`b_reg[0]` (LSB first). On `s_tick`, if `s_cnt`=15, shift `b_reg` right and clear `s_cnt`. If `n_cnt`=`DBIT-1`, go to STOP; otherwise increment `n_cnt`.
  - STOP: `tx`=1. On `s_tick`, if `s_cnt`=`SB_TICK-1`, pulse `tx_done_tick` and go to IDLE; otherwise increment `s_cnt`.
- No parity bit. The FIFO read is combinational from the head entry; the pop is registered into `b_reg`.

## Timing
- One tick = `DVSR+1` clocks. One bit = `16*(DVSR+1)` clocks. Defaults: 80 clocks per tick, 1280 clocks per bit.
- Frame length = `(1+DBIT)*16*(DVSR+1) + SB_TICK*(DVSR+1)` clocks. Default: 12800 clocks.
- Latency when idle and empty:
  - `wr_uart` sampled at edge k.
  - `tx_empty` falls after edge k.
  - Pop and START entry happen at edge k+1; `tx` goes low after edge k+1.
- Back-to-back frames: `tx_done_tick` is high in the last STOP cycle and the FSM enters IDLE at that edge. If the FIFO is non-empty, the next START is entered one clock later. The inter-frame gap is the stop bit plus exactly 1 clock.
- `tx_full` rises after the edge that writes entry `2^FIFO_W`. It falls after the edge of the next pop.
- `tx_busy` is 1 from START entry until IDLE re-entry.

## Test plan
- Reset: hold `reset`=0, then release → `tx`=1, `tx_empty`=1, `tx_full`=0, `tx_busy`=0; no activity for 20000 clocks.
- Single byte: write 0xA5 at edge k (defaults) → `tx` low from k+1 for 1280 clocks, then bits 1,0,1,0,0,1,0,1 at 1280 clocks each, then high for 1280 clocks. `tx_done_tick` pulses once at clock k+12800; the bench checks the decoded byte equals 0xA5.
- Fill and overflow: write 20 distinct bytes on consecutive clocks into an idle FIFO (depth 16) → `tx_full` asserts. The first 17 bytes are transmitted in order (one popped immediately, 16 buffered), the rest are dropped, and `tx_empty`=1 after the last frame.
- Back-to-back: queue 0x00 and 0xFF → the gap between the stop-bit end and the next start edge is exactly 1 clock; the frames decode in order.
- Reset mid-frame: assert `reset`=0 during the DATA state of 0x3C → `tx`=1 asynchronously and the FIFO is empty. After release, write 0x81 → a clean 0x81 frame is sent.
- Divider and stop variants: `DVSR`=3, `SB_TICK`=32 → bit period 64 clocks, stop length 128 clocks; frame 0x5A decodes correctly.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a circular write FIFO feeding an oversampled 8N1-style
// serialiser whose baud tick comes from a programmable clock divider.
module uart_tx_fifo #(
    parameter int DVSR     = 79,
    parameter int DVSR_BIT = 7,
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int FIFO_W   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] w_data,
    output logic            tx_full,
    output logic            tx_empty,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int DEPTH = 2 ** FIFO_W;
    localparam int S_W   = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int N_W   = $clog2((DBIT > 1) ? DBIT : 2);

    localparam logic [DVSR_BIT-1:0] DVSR_MAX = DVSR_BIT'(DVSR);
    localparam logic [S_W-1:0]      S_LAST   = S_W'(15);
    localparam logic [S_W-1:0]      SB_LAST  = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0]      N_LAST   = N_W'(DBIT - 1);
    localparam logic [FIFO_W-1:0]   PTR_ONE  = FIFO_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic [DBIT-1:0]     mem_q [DEPTH];
    logic [FIFO_W-1:0]   w_ptr_q, w_ptr_d;
    logic [FIFO_W-1:0]   r_ptr_q, r_ptr_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                wr_en;
    logic                rd_en;

    state_e              state_q, state_d;
    logic [DVSR_BIT-1:0] div_q, div_d;
    logic [S_W-1:0]      s_cnt_q, s_cnt_d;
    logic [N_W-1:0]      n_cnt_q, n_cnt_d;
    logic [DBIT-1:0]     b_q, b_d;
    logic                tx_q, tx_d;
    logic                s_tick;
    logic                done;

    // A write while full is dropped even if the serialiser pops in the same cycle.
    assign wr_en = wr_uart & ~full_q;

    // NOTE: storage is deliberately not reset; the pointers and flags alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[w_ptr_q] <= w_data;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        full_d  = full_q;
        empty_d = empty_q;
        unique case ({wr_en, rd_en})
            2'b10: begin
                w_ptr_d = w_ptr_q + PTR_ONE;
                empty_d = 1'b0;
                full_d  = ((w_ptr_q + PTR_ONE) == r_ptr_q);
            end
            2'b01: begin
                r_ptr_d = r_ptr_q + PTR_ONE;
                full_d  = 1'b0;
                empty_d = ((r_ptr_q + PTR_ONE) == w_ptr_q);
            end
            2'b11: begin
                w_ptr_d = w_ptr_q + PTR_ONE;
                r_ptr_d = r_ptr_q + PTR_ONE;
            end
            default: begin
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // The divider only runs while a frame is on the line, so every frame starts phase-aligned.
    assign s_tick = (div_q == DVSR_MAX);

    always_comb begin
        div_d = div_q + DVSR_BIT'(1);
        if (state_q == IDLE || s_tick) begin
            div_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        rd_en   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    rd_en   = 1'b1;
                    b_d     = mem_q[r_ptr_q];
                    s_cnt_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        b_d     = b_q >> 1;
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + N_W'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == SB_LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
        endcase
    end

    // The line level is derived from the next state so tx changes on the same edge as the FSM.
    always_comb begin
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    assign tx           = tx_q;
    assign tx_full      = full_q;
    assign tx_empty     = empty_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a default-rate instance and a fast variant
// (DVSR=3, SB_TICK=32), driven from a vector table plus hand-written corner sequences.
module tb_uart_tx_fifo;

    localparam int A_BIT  = 1280;
    localparam int A_STOP = 1280;
    localparam int B_BIT  = 64;
    localparam int B_STOP = 128;
    localparam int B_FRAME = 9 * B_BIT + B_STOP;

    typedef struct {
        bit         inst;
        logic [7:0] din;
        logic [7:0] exp_byte;
        int         exp_lat;
        int         bit_clks;
        int         stop_clks;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a_n, rst_b_n;
    logic       wr_a, wr_b;
    logic [7:0] wd_a, wd_b;
    logic       full_a, empty_a, busy_a, done_a, tx_a;
    logic       full_b, empty_b, busy_b, done_b, tx_b;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.DVSR(79), .DVSR_BIT(7), .DBIT(8), .SB_TICK(16), .FIFO_W(4)) dut_a (
        .clk(clk), .reset(rst_a_n), .wr_uart(wr_a), .w_data(wd_a),
        .tx_full(full_a), .tx_empty(empty_a), .tx_busy(busy_a),
        .tx_done_tick(done_a), .tx(tx_a)
    );

    uart_tx_fifo #(.DVSR(3), .DVSR_BIT(2), .DBIT(8), .SB_TICK(32), .FIFO_W(4)) dut_b (
        .clk(clk), .reset(rst_b_n), .wr_uart(wr_b), .w_data(wd_b),
        .tx_full(full_b), .tx_empty(empty_b), .tx_busy(busy_b),
        .tx_done_tick(done_b), .tx(tx_b)
    );

    function automatic int tx_of(input bit b);
        return b ? int'(tx_b) : int'(tx_a);
    endfunction
    function automatic int busy_of(input bit b);
        return b ? int'(busy_b) : int'(busy_a);
    endfunction
    function automatic int empty_of(input bit b);
        return b ? int'(empty_b) : int'(empty_a);
    endfunction
    function automatic int done_of(input bit b);
        return b ? int'(done_b) : int'(done_a);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no event expected one within the cycle budget", name);
    endtask

    // Writes one byte at the next rising edge; returns that edge's index at the following negedge.
    task automatic write_byte(input bit b, input logic [7:0] d, output int k);
        @(negedge clk);
        if (b) begin
            wr_b = 1'b1;
            wd_b = d;
        end else begin
            wr_a = 1'b1;
            wd_a = d;
        end
        @(negedge clk);
        wr_a = 1'b0;
        wr_b = 1'b0;
        k = cyc;
    endtask

    // Called at a negedge; finds the start edge, samples mid-bit, then times tx_done_tick.
    task automatic rx_frame(input bit b, input int bit_clks, input int stop_clks, input string tag,
                            output logic [7:0] data, output int start, output int done_at);
        int limit;
        int frame;
        frame   = 9 * bit_clks + stop_clks;
        data    = '0;
        start   = -1;
        done_at = -1;
        limit   = cyc + 2 * frame + 16;
        while (tx_of(b) != 0 && cyc < limit) @(negedge clk);
        if (tx_of(b) != 0) begin
            timeout_fail({tag, " start"});
            return;
        end
        start = cyc;
        while (cyc < start + bit_clks / 2) @(negedge clk);
        check({tag, " start bit"}, tx_of(b), 0);
        check({tag, " busy"}, busy_of(b), 1);
        for (int i = 0; i < 8; i++) begin
            while (cyc < start + bit_clks * (i + 1) + bit_clks / 2) @(negedge clk);
            data[i] = (tx_of(b) != 0);
        end
        while (cyc < start + 9 * bit_clks + stop_clks / 2) @(negedge clk);
        check({tag, " stop bit"}, tx_of(b), 1);
        limit = start + frame + 4;
        while (done_of(b) != 1 && cyc < limit) @(negedge clk);
        if (done_of(b) != 1) begin
            timeout_fail({tag, " done"});
            return;
        end
        done_at = cyc;
        check({tag, " done time"}, done_at - start, frame - 1);
        @(negedge clk);
        check({tag, " done width"}, done_of(b), 0);
    endtask

    initial begin
        vec_t       vecs[6];
        int         k, s, d, s2, d2, bad;
        logic [7:0] got;

        vecs[0] = '{1'b0, 8'hA5, 8'hA5, 1, A_BIT, A_STOP};
        vecs[1] = '{1'b1, 8'h5A, 8'h5A, 1, B_BIT, B_STOP};
        vecs[2] = '{1'b1, 8'h00, 8'h00, 1, B_BIT, B_STOP};
        vecs[3] = '{1'b1, 8'hFF, 8'hFF, 1, B_BIT, B_STOP};
        vecs[4] = '{1'b1, 8'h01, 8'h01, 1, B_BIT, B_STOP};
        vecs[5] = '{1'b1, 8'h80, 8'h80, 1, B_BIT, B_STOP};

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        wr_a = 1'b0; wr_b = 1'b0;
        wd_a = '0;   wd_b = '0;
        repeat (3) @(negedge clk);
        check("rst tx", int'(tx_a), 1);
        check("rst empty", int'(empty_a), 1);
        check("rst full", int'(full_a), 0);
        check("rst busy", int'(busy_a), 0);
        check("rst done", int'(done_a), 0);
        check("rst tx_b", int'(tx_b), 1);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        bad = 0;
        repeat (20000) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || empty_a !== 1'b1 || done_a !== 1'b0) bad++;
        end
        check("idle quiet cycles", bad, 0);

        for (int i = 0; i < 6; i++) begin
            write_byte(vecs[i].inst, vecs[i].din, k);
            check($sformatf("v%0d empty after write", i), empty_of(vecs[i].inst), 0);
            check($sformatf("v%0d idle at write", i), busy_of(vecs[i].inst), 0);
            rx_frame(vecs[i].inst, vecs[i].bit_clks, vecs[i].stop_clks, $sformatf("v%0d", i), got, s, d);
            check($sformatf("v%0d latency", i), s - k, vecs[i].exp_lat);
            check($sformatf("v%0d byte", i), int'(got), int'(vecs[i].exp_byte));
            check($sformatf("v%0d busy after", i), busy_of(vecs[i].inst), 0);
            check($sformatf("v%0d empty after", i), empty_of(vecs[i].inst), 1);
        end

        // Back-to-back: the second frame starts one clock after the first stop bit ends.
        @(negedge clk);
        wr_b = 1'b1; wd_b = 8'h00;
        @(negedge clk);
        wd_b = 8'hFF;
        @(negedge clk);
        wr_b = 1'b0;
        rx_frame(1'b1, B_BIT, B_STOP, "b2b0", got, s, d);
        check("b2b0 byte", int'(got), 8'h00);
        rx_frame(1'b1, B_BIT, B_STOP, "b2b1", got, s2, d2);
        check("b2b1 byte", int'(got), 8'hFF);
        check("b2b gap", s2 - (s + B_FRAME), 1);
        check("b2b empty after", int'(empty_b), 1);

        // Fill and overflow: 20 consecutive writes, only the first 17 survive.
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    check($sformatf("fill full before write %0d", i), int'(full_b), (i >= 17) ? 1 : 0);
                    wr_b = 1'b1;
                    wd_b = 8'h30 + 8'(i);
                    @(negedge clk);
                end
                wr_b = 1'b0;
                check("fill full after writes", int'(full_b), 1);
            end
            begin
                int fs, fd;
                logic [7:0] fg;
                for (int j = 0; j < 17; j++) begin
                    rx_frame(1'b1, B_BIT, B_STOP, $sformatf("fill%0d", j), fg, fs, fd);
                    check($sformatf("fill%0d byte", j), int'(fg), 8'h30 + j);
                    if (j == 0) begin
                        check("full held before pop", int'(full_b), 1);
                        @(negedge clk);
                        check("full cleared by pop", int'(full_b), 0);
                    end
                end
            end
        join
        check("fill empty at end", int'(empty_b), 1);
        bad = 0;
        repeat (2 * B_FRAME) begin
            @(negedge clk);
            if (tx_b !== 1'b1 || busy_b !== 1'b0) bad++;
        end
        check("fill no extra frame", bad, 0);

        // Reset mid-frame: 0x3C on the line, 0x99 queued behind it.
        @(negedge clk);
        wr_a = 1'b1; wd_a = 8'h3C;
        @(negedge clk);
        wd_a = 8'h99;
        @(negedge clk);
        wr_a = 1'b0;
        s = cyc;
        while (cyc < s + 2 * A_BIT + 100) @(negedge clk);
        check("mid busy", int'(busy_a), 1);
        check("mid data bit1", int'(tx_a), 0);
        check("mid queued", int'(empty_a), 0);
        #1 rst_a_n = 1'b0;
        #1;
        check("async rst tx", int'(tx_a), 1);
        check("async rst empty", int'(empty_a), 1);
        check("async rst busy", int'(busy_a), 0);
        repeat (3) @(negedge clk);
        rst_a_n = 1'b1;
        write_byte(1'b0, 8'h81, k);
        rx_frame(1'b0, A_BIT, A_STOP, "post rst", got, s, d);
        check("post rst latency", s - k, 1);
        check("post rst byte", int'(got), 8'h81);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("post rst quiet", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
